// File: rtl/db_cmd_pkg.sv
// Shared definitions for the debug command sequencer: FSM states, ASCII
// constants and small character helpers. The ACK states exist only when
// DB_WRITE_ACK_EN is defined.
package db_cmd_pkg;

    localparam logic [7:0] CH_P  = 8'h70;  // 'p'
    localparam logic [7:0] CH_R  = 8'h72;  // 'r'
    localparam logic [7:0] CH_G  = 8'h67;  // 'g'
    localparam logic [7:0] CH_H  = 8'h68;  // 'h'
    localparam logic [7:0] CH_SP = 8'h20;  // ' '
    localparam logic [7:0] CH_LF = 8'h0A;  // '\n'
    localparam logic [7:0] CH_CR = 8'h0D;  // '\r'
    localparam logic [7:0] CH_Q  = 8'h3F;  // '?'
    localparam logic [7:0] CH_K  = 8'h4B;  // 'K'

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEP1,
        S_ADDR,
        S_DATA,
        S_MEM,
        S_RESP_HI,
        S_RESP_LO,
        S_RESP_NL,
        S_DRAIN,
        S_ERR_Q,
        S_ERR_NL
`ifdef DB_WRITE_ACK_EN
        ,
        S_ACK_K,
        S_ACK_NL
`endif
    } state_t;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters 'a'-'f' and 'A'-'F' share a low nibble of 1..6.
    function automatic logic [3:0] hex2nib(input logic [7:0] c);
        if (c <= 8'h39) return c[3:0];
        else            return c[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
        else                          return c;
    endfunction

endpackage

// File: rtl/db_nib2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module db_nib2ascii (
    input  logic [3:0] nib,
    output logic [7:0] ch
);

    // '0'..'9' for 0..9, 'A'..'F' for 10..15
    always_comb begin
        if (nib < 4'd10) ch = 8'h30 + {4'b0000, nib};
        else             ch = 8'h37 + {4'b0000, nib};
    end

endmodule

// File: rtl/db_cmd_sequencer.sv
// Debug-port command sequencer: parses "p AAAA DD", "r AAAA", "g", "h"
// line commands from the debug UART, drives the RAM load port and returns
// ASCII responses. Optional macro DB_WRITE_ACK_EN adds a "K\n" reply
// after each completed write.
module db_cmd_sequencer
    import db_cmd_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_ADIG = ADDR_W / 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W = $clog2(MAX_ADIG + 1) + 1;

    state_t              state, state_n;
    logic [7:0]          cmd, cmd_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [DATA_W-1:0]   data, data_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   rdata, rdata_n;
    logic                mem_req_n, mem_we_n, cpu_run_n, overrun_n;
    logic [7:0]          hi_ch, lo_ch;
    logic [7:0]          lc;
    logic                hex, parse;
    logic [3:0]          nib;

    db_nib2ascii u_hi (.nib(rdata[7:4]), .ch(hi_ch));
    db_nib2ascii u_lo (.nib(rdata[3:0]), .ch(lo_ch));

    assign mem_addr  = addr;
    assign mem_wdata = data;
    assign lc        = to_lower(rx_data);
    assign hex       = is_hex(rx_data);
    assign nib       = hex2nib(rx_data);
    // '\r' is invisible to the parser
    assign parse     = rx_valid && (rx_data != CH_CR);

    // State and datapath registers; reset clears everything, aborting any
    // memory request or pending transmit
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cmd     <= '0;
            addr    <= '0;
            data    <= '0;
            cnt     <= '0;
            rdata   <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            cpu_run <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cmd     <= cmd_n;
            addr    <= addr_n;
            data    <= data_n;
            cnt     <= cnt_n;
            rdata   <= rdata_n;
            mem_req <= mem_req_n;
            mem_we  <= mem_we_n;
            cpu_run <= cpu_run_n;
            overrun <= overrun_n;
        end
    end

    // Next-state, datapath updates and Moore tx outputs
    always_comb begin
        state_n   = state;
        cmd_n     = cmd;
        addr_n    = addr;
        data_n    = data;
        cnt_n     = cnt;
        rdata_n   = rdata;
        mem_req_n = mem_req;
        mem_we_n  = mem_we;
        cpu_run_n = cpu_run;
        overrun_n = overrun;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        busy      = 1'b1;

        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (parse) begin
                    if (lc == CH_P || lc == CH_R || lc == CH_G || lc == CH_H) begin
                        cmd_n   = lc;
                        addr_n  = '0;
                        data_n  = '0;
                        cnt_n   = '0;
                        state_n = S_SEP1;
                    end else if (rx_data != CH_LF) begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_SEP1: begin
                busy = 1'b0;
                if (parse) begin
                    if (rx_data == CH_SP && (cmd == CH_P || cmd == CH_R))
                        state_n = S_ADDR;
                    else if (rx_data == CH_LF) begin
                        if (cmd == CH_G) begin
                            cpu_run_n = 1'b1;
                            state_n   = S_IDLE;
                        end else if (cmd == CH_H) begin
                            cpu_run_n = 1'b0;
                            state_n   = S_IDLE;
                        end else
                            state_n = S_ERR_Q;
                    end else
                        state_n = S_DRAIN;
                end
            end
            S_ADDR: begin
                busy = 1'b0;
                if (parse) begin
                    if (hex) begin
                        if (cnt == CNT_W'(MAX_ADIG))
                            state_n = S_DRAIN;
                        else begin
                            addr_n = (addr << 4) | ADDR_W'(nib);
                            cnt_n  = cnt + 1'b1;
                        end
                    end else if (rx_data == CH_SP && cnt != '0 && cmd == CH_P) begin
                        cnt_n   = '0;
                        state_n = S_DATA;
                    end else if (rx_data == CH_LF) begin
                        if (cnt != '0 && cmd == CH_R) begin
                            mem_we_n = 1'b0;
                            state_n  = S_MEM;
                        end else
                            state_n = S_ERR_Q;
                    end else
                        state_n = S_DRAIN;
                end
            end
            S_DATA: begin
                busy = 1'b0;
                if (parse) begin
                    if (hex) begin
                        if (cnt == CNT_W'(2))
                            state_n = S_DRAIN;
                        else begin
                            data_n = {data[DATA_W-5:0], nib};
                            cnt_n  = cnt + 1'b1;
                        end
                    end else if (rx_data == CH_LF) begin
                        if (cnt != '0) begin
                            mem_we_n = 1'b1;
                            state_n  = S_MEM;
                        end else
                            state_n = S_ERR_Q;
                    end else
                        state_n = S_DRAIN;
                end
            end
            S_MEM: begin
                // request rises the cycle after entry, drops with the ack
                if (!mem_req)
                    mem_req_n = 1'b1;
                else if (mem_ack) begin
                    mem_req_n = 1'b0;
                    if (mem_we) begin
`ifdef DB_WRITE_ACK_EN
                        state_n = S_ACK_K;
`else
                        state_n = S_IDLE;
`endif
                    end else begin
                        rdata_n = mem_rdata;
                        state_n = S_RESP_HI;
                    end
                end
            end
            S_RESP_HI: begin
                tx_valid = 1'b1;
                tx_data  = hi_ch;
                if (tx_ready) state_n = S_RESP_LO;
            end
            S_RESP_LO: begin
                tx_valid = 1'b1;
                tx_data  = lo_ch;
                if (tx_ready) state_n = S_RESP_NL;
            end
            S_RESP_NL: begin
                tx_valid = 1'b1;
                tx_data  = CH_LF;
                if (tx_ready) state_n = S_IDLE;
            end
            S_DRAIN: begin
                busy = 1'b0;
                if (rx_valid && rx_data == CH_LF) state_n = S_ERR_Q;
            end
            S_ERR_Q: begin
                tx_valid = 1'b1;
                tx_data  = CH_Q;
                if (tx_ready) state_n = S_ERR_NL;
            end
            S_ERR_NL: begin
                tx_valid = 1'b1;
                tx_data  = CH_LF;
                if (tx_ready) state_n = S_IDLE;
            end
`ifdef DB_WRITE_ACK_EN
            S_ACK_K: begin
                tx_valid = 1'b1;
                tx_data  = CH_K;
                if (tx_ready) state_n = S_ACK_NL;
            end
            S_ACK_NL: begin
                tx_valid = 1'b1;
                tx_data  = CH_LF;
                if (tx_ready) state_n = S_IDLE;
            end
`endif
            default: begin
                busy    = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        // bytes arriving while busy are lost; flag it until reset
        if (rx_valid && busy) overrun_n = 1'b1;
    end

endmodule

// File: tb/tb_db_cmd_sequencer.sv
// Directed self-checking bench for db_cmd_sequencer.
module tb_db_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        cpu_run;
    logic        busy;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    int          mem_wait = 0;
    logic [7:0]  rd_value = 8'h00;
    int          wcnt = 0;
    int          mem_n = 0;
    logic        last_we;
    logic [15:0] last_addr;
    logic [7:0]  last_wdata;
    byte         txq[$];

    db_cmd_sequencer #(.ADDR_W(16), .DATA_W(8), .MAX_ADIG(4)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cpu_run(cpu_run), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // memory responder: acks after mem_wait extra request cycles
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wcnt == mem_wait) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd_value;
                    last_we = mem_we;
                    last_addr = mem_addr;
                    last_wdata = mem_wdata;
                    mem_n++;
                    wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // transmit monitor
    initial begin
        forever begin
            @(negedge clk);
            if (tx_valid && tx_ready) txq.push_back(tx_data);
        end
    end

    function automatic string txs();
        string s = "";
        foreach (txq[i]) s = $sformatf("%s%c", s, txq[i]);
        return s;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b1;
        step(3);
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_we got %b%b want 00", mem_req, mem_we); end
        n_vec++; if (mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin n_err++; $display("FAIL reset_addr_wdata got %h %h want 0000 00", mem_addr, mem_wdata); end
        n_vec++; if (cpu_run !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL reset_flags got %b%b%b want 000", cpu_run, busy, overrun); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_write();
        logic exp_busy;
`ifdef DB_WRITE_ACK_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        mem_wait = 0;
        mem_n = 0;
        txq.delete();
        send_str("p 1A 5C\n");
        @(negedge clk);
        n_vec++; if (busy !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL wr_mem_entry busy/req got %b%b want 10", busy, mem_req); end
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL wr_req got req/we %b%b want 11", mem_req, mem_we); end
        n_vec++; if (mem_addr !== 16'h001A || mem_wdata !== 8'h5C) begin n_err++; $display("FAIL wr_addr_data got %h %h want 001a 5c", mem_addr, mem_wdata); end
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b0 || busy !== exp_busy) begin n_err++; $display("FAIL wr_done req/busy got %b%b want 0%b", mem_req, busy, exp_busy); end
        step(6);
        n_vec++; if (mem_n !== 1 || last_we !== 1'b1) begin n_err++; $display("FAIL wr_count got %0d we %b want 1 we 1", mem_n, last_we); end
`ifdef DB_WRITE_ACK_EN
        n_vec++; if (txs() != "K\n") begin n_err++; $display("FAIL wr_ack_tx got %0d bytes want K+LF", txq.size()); end
`else
        n_vec++; if (txq.size() != 0) begin n_err++; $display("FAIL wr_no_tx got %0d bytes want 0", txq.size()); end
`endif
        mem_n = 0;
        send_str("P FFFF f\n");
        step(8);
        n_vec++; if (mem_n !== 1 || last_addr !== 16'hFFFF || last_wdata !== 8'h0F) begin n_err++; $display("FAIL wr_ffff got n=%0d %h %h want 1 ffff 0f", mem_n, last_addr, last_wdata); end
    endtask

    task automatic test_read();
        int  first;
        logic found;
        mem_wait = 3;
        rd_value = 8'hB7;
        mem_n = 0;
        txq.delete();
        tx_ready = 1'b0;
        send_str("r 001a\n");
        first = -1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (tx_valid) begin found = 1'b1; first = k; end
        end
        n_vec++; if (first != 5) begin n_err++; $display("FAIL rd_latency got %0d want 5", first); end
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin n_err++; $display("FAIL rd_hold_B cycle %0d got %b %h want 1 42", k, tx_valid, tx_data); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        step(6);
        n_vec++; if (txs() != "B7\n") begin n_err++; $display("FAIL rd_resp got %0d bytes [%s] want B7+LF", txq.size(), txs()); end
        n_vec++; if (mem_n !== 1 || last_we !== 1'b0 || last_addr !== 16'h001A) begin n_err++; $display("FAIL rd_req got n=%0d we=%b %h want 1 0 001a", mem_n, last_we, last_addr); end
    endtask

    task automatic test_errors();
        mem_wait = 0;
        mem_n = 0;
        txq.delete();
        send_str("x 12\n");
        step(6);
        n_vec++; if (txs() != "?\n" || mem_n != 0) begin n_err++; $display("FAIL err_badcmd got [%s] n=%0d want ?+LF n=0", txs(), mem_n); end
        txq.delete();
        send_str("r 12345\n");
        step(6);
        n_vec++; if (txs() != "?\n" || mem_n != 0) begin n_err++; $display("FAIL err_long_addr got [%s] n=%0d want ?+LF n=0", txs(), mem_n); end
        txq.delete();
        send_str("p 1 234\n");
        step(6);
        n_vec++; if (txs() != "?\n" || mem_n != 0) begin n_err++; $display("FAIL err_long_data got [%s] n=%0d want ?+LF n=0", txs(), mem_n); end
    endtask

    task automatic test_run();
        mem_n = 0;
        txq.delete();
        send_str("g\n");
        step(2);
        n_vec++; if (cpu_run !== 1'b1 || txq.size() != 0) begin n_err++; $display("FAIL run_go got %b tx=%0d want 1 0", cpu_run, txq.size()); end
        send_str("H\r\n");
        step(2);
        n_vec++; if (cpu_run !== 1'b0 || txq.size() != 0) begin n_err++; $display("FAIL run_halt got %b tx=%0d want 0 0", cpu_run, txq.size()); end
        send_str("\r\n");
        step(4);
        n_vec++; if (txq.size() != 0 || busy !== 1'b0 || mem_n != 0) begin n_err++; $display("FAIL run_empty got tx=%0d busy=%b n=%0d want 0 0 0", txq.size(), busy, mem_n); end
    endtask

    task automatic test_overrun();
        mem_wait = 0;
        rd_value = 8'h3C;
        txq.delete();
        tx_ready = 1'b0;
        send_str("r 5\n");
        step(2);
        send_byte(8'h7A);
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b want 1", overrun); end
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin n_err++; $display("FAIL ovr_hi got %b %h want 1 33", tx_valid, tx_data); end
        tx_ready = 1'b1;
        step(6);
        n_vec++; if (txs() != "3C\n") begin n_err++; $display("FAIL ovr_resp got [%s] want 3C+LF", txs()); end
        mem_n = 0;
        send_str("p 0 0\n");
        step(8);
        n_vec++; if (mem_n !== 1 || last_we !== 1'b1 || last_addr !== 16'h0 || last_wdata !== 8'h0) begin n_err++; $display("FAIL ovr_next_wr got n=%0d we=%b %h %h want 1 1 0000 00", mem_n, last_we, last_addr, last_wdata); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid();
        send_str("g\n");
        step(2);
        mem_wait = 50;
        send_str("r 7\n");
        step(3);
        n_vec++; if (mem_req !== 1'b1 || cpu_run !== 1'b1) begin n_err++; $display("FAIL rst_pre got req=%b run=%b want 1 1", mem_req, cpu_run); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++; if (mem_req !== 1'b0 || tx_valid !== 1'b0 || cpu_run !== 1'b0) begin n_err++; $display("FAIL rst_mid got req=%b txv=%b run=%b want 000", mem_req, tx_valid, cpu_run); end
        n_vec++; if (busy !== 1'b0 || overrun !== 1'b0 || mem_addr !== 16'h0) begin n_err++; $display("FAIL rst_mid_state got busy=%b ovr=%b addr=%h want 0 0 0000", busy, overrun, mem_addr); end
        mem_wait = 0;
        rd_value = 8'h5A;
        mem_n = 0;
        txq.delete();
        send_str("r 0\n");
        step(8);
        n_vec++; if (txs() != "5A\n" || mem_n != 1) begin n_err++; $display("FAIL rst_after_rd got [%s] n=%0d want 5A+LF n=1", txs(), mem_n); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_run();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
